dlat_stim_chk: RTL and testbench

- Clocked stimulus generator and checker for a transparent-high D-latch standard cell.
- Drives the latch's data and gate pins (LAT_D, LAT_G) through a programmable setup/gate/hold/opaque sequence, then samples LAT_Q.
- Checks transparency while the gate is open and retention while it is closed.
- Used in cell bring-up benches and on-silicon self-test wrappers, one instance per latch under test.

---
 rtl/dlat_tst_pkg.sv | 27 ++
 rtl/dlat_stim_chk_if.sv | 24 ++
 rtl/dlat_stim_chk_lfsr8.sv | 31 +++
 rtl/dlat_stim_chk.sv | 177 +++++++++++++++++
 tb/tb_dlat_stim_chk.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlat_tst_pkg.sv
// Shared types and constants for the D-latch stimulus/checker block.
package dlat_tst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_GATE,
        ST_HOLD,
        ST_OPAQUE,
        ST_DONE
    } state_e;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] SEED_DEFAULT = 8'h01;
    localparam logic [7:0] ERR_MAX      = 8'hFF;

    // Feedback is the parity of bits 7,5,4,3 shifted into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/dlat_stim_chk_if.sv
// Control, status and latch-pin bundle of the D-latch stimulus/checker.
interface dlat_stim_chk_if;
    logic       START;
    logic [7:0] SEED;
    logic [7:0] NPAT;
    logic       LAT_D;
    logic       LAT_G;
    logic       LAT_Q;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [7:0] ERR_CNT;
    logic [7:0] FIRST_FAIL;

    modport master (
        output START, SEED, NPAT, LAT_Q,
        input  LAT_D, LAT_G, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL
    );

    modport slave (
        input  START, SEED, NPAT, LAT_Q,
        output LAT_D, LAT_G, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL
    );
endinterface

// File: rtl/dlat_stim_chk_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and advance enable; also exposes its next value.
module lfsr8
    import dlat_tst_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q,
    output logic [7:0] q_nxt_c
);

    always_comb begin
        q_nxt_c = q;
        if (load) begin
            q_nxt_c = seed_fix(seed);
        end else if (adv) begin
            q_nxt_c = lfsr_step(q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= SEED_DEFAULT;
        end else begin
            q <= q_nxt_c;
        end
    end

endmodule

// File: rtl/dlat_stim_chk.sv
// Drives a transparent-high latch through setup/gate/hold/opaque phases per pattern
// and checks transparency and retention on LAT_Q.
module dlat_stim_chk
    import dlat_tst_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned GATE_CYC  = 3,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned OPQ_CYC   = 2
) (
    input  logic           CLK,
    input  logic           RST,
    dlat_stim_chk_if.slave bus
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int unsigned MAX_CD  = (HOLD_CYC > OPQ_CYC) ? HOLD_CYC : OPQ_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LEN_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam cnt_t LEN_GATE  = CNT_W'(GATE_CYC - 1);
    localparam cnt_t LEN_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam cnt_t LEN_OPQ   = CNT_W'(OPQ_CYC - 1);

    // Phase counter reload value: counts down to zero on the last cycle of a phase.
    function automatic cnt_t phase_len(input state_e s);
        case (s)
            ST_SETUP:  return LEN_SETUP;
            ST_GATE:   return LEN_GATE;
            ST_HOLD:   return LEN_HOLD;
            ST_OPAQUE: return LEN_OPQ;
            default:   return '0;
        endcase
    endfunction

    state_e     state_q, state_nxt;
    cnt_t       cnt_q, cnt_nxt;
    logic [7:0] idx_q, idx_nxt;
    logic [7:0] npat_q, npat_nxt;
    logic [7:0] err_q, err_nxt;
    logic [7:0] ff_q, ff_nxt;
    logic       pass_q, pass_nxt;
    logic       lat_d_q, lat_d_nxt;
    logic       lat_g_q, lat_g_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       lfsr_load_c, lfsr_adv_c, sample_c;
    logic [7:0] lfsr_q, lfsr_nxt_c;

    lfsr8 u_lfsr (
        .CLK     (CLK),
        .RST     (RST),
        .load    (lfsr_load_c),
        .seed    (bus.SEED),
        .adv     (lfsr_adv_c),
        .q       (lfsr_q),
        .q_nxt_c (lfsr_nxt_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            npat_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            lat_d_q <= 1'b0;
            lat_g_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            npat_q  <= npat_nxt;
            err_q   <= err_nxt;
            ff_q    <= ff_nxt;
            pass_q  <= pass_nxt;
            lat_d_q <= lat_d_nxt;
            lat_g_q <= lat_g_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        npat_nxt    = npat_q;
        err_nxt     = err_q;
        ff_nxt      = ff_q;
        pass_nxt    = pass_q;
        lfsr_load_c = 1'b0;
        lfsr_adv_c  = 1'b0;
        sample_c    = 1'b0;
        lat_d_nxt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    lfsr_load_c = 1'b1;
                    idx_nxt     = '0;
                    npat_nxt    = bus.NPAT;
                    err_nxt     = '0;
                    ff_nxt      = '0;
                    pass_nxt    = 1'b0;
                    state_nxt   = (bus.NPAT == 8'd0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_nxt = ST_GATE;
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    sample_c  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_nxt = ST_OPAQUE;
            end
            ST_OPAQUE: begin
                if (cnt_q == '0) begin
                    sample_c = 1'b1;
                    if (idx_q == npat_q - 8'd1) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt    = idx_q + 8'd1;
                        lfsr_adv_c = 1'b1;
                        state_nxt  = ST_SETUP;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Both checks expect LAT_Q to equal the pattern bit.
        if (sample_c && (bus.LAT_Q != lfsr_q[0])) begin
            if (err_q == 8'd0) ff_nxt = idx_q;
            if (err_q != ERR_MAX) err_nxt = err_q + 8'd1;
        end

        if (state_nxt != state_q) begin
            cnt_nxt = phase_len(state_nxt);
        end else if (cnt_q != '0) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end

        if (state_nxt == ST_DONE) pass_nxt = (err_nxt == 8'd0);

        // Pin values are computed for the upcoming state so they line up with it.
        case (state_nxt)
            ST_SETUP, ST_GATE, ST_HOLD: lat_d_nxt = lfsr_nxt_c[0];
            ST_OPAQUE:                  lat_d_nxt = ~lfsr_nxt_c[0];
            default:                    lat_d_nxt = 1'b0;
        endcase
        lat_g_nxt = (state_nxt == ST_GATE);
        busy_nxt  = (state_nxt inside {ST_SETUP, ST_GATE, ST_HOLD, ST_OPAQUE});
        done_nxt  = (state_nxt == ST_DONE);
    end

    assign bus.LAT_D      = lat_d_q;
    assign bus.LAT_G      = lat_g_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.ERR_CNT    = err_q;
    assign bus.FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_dlat_stim_chk.sv
// Directed bench for dlat_stim_chk against ideal, stuck-at and always-transparent latch models.
module tb_dlat_stim_chk;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dlat_stim_chk_if bus ();

    dlat_stim_chk #(
        .SETUP_CYC (2),
        .GATE_CYC  (3),
        .HOLD_CYC  (2),
        .OPQ_CYC   (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Latch models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 always transparent.
    logic [1:0] mode = 2'd0;
    logic       held_q = 1'b0;
    always @(negedge CLK) if (bus.LAT_G) held_q <= bus.LAT_D;
    assign bus.LAT_Q = (mode == 2'd0) ? (bus.LAT_G ? bus.LAT_D : held_q) :
                       (mode == 2'd1) ? 1'b0 :
                       (mode == 2'd2) ? 1'b1 : bus.LAT_D;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns positioned in the first cycle after the START edge.
    task automatic start_run(input logic [7:0] seed, input logic [7:0] npat);
        bus.SEED  = seed;
        bus.NPAT  = npat;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Cycle index (1 = first cycle after START) at which DONE is seen, bounded by limit.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (bus.DONE !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.START = 1'b0;
        bus.SEED  = 8'h00;
        bus.NPAT  = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({bus.LAT_D, bus.LAT_G, bus.BUSY, bus.DONE, bus.PASS} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.LAT_D, bus.LAT_G, bus.BUSY, bus.DONE, bus.PASS});
        else n_pass++;
        n_checks++;
        if (bus.ERR_CNT !== 8'd0) $display("FAIL reset_err: got %0d want 0", bus.ERR_CNT);
        else n_pass++;
        n_checks++;
        if (bus.FIRST_FAIL !== 8'd0) $display("FAIL reset_ff: got %0d want 0", bus.FIRST_FAIL);
        else n_pass++;
        RST = 1'b0;
        tick();
    endtask

    // Full cycle-by-cycle waveform for an ideal latch, patterns 1,0,0,0.
    task automatic test_ideal();
        logic [3:0] bits = 4'b0001;
        mode = 2'd0;
        start_run(8'h01, 8'd4);
        for (int c = 1; c <= 38; c++) begin
            logic [3:0] exp_v;
            int p, ph;
            exp_v = 4'b0000;
            if (c <= 36) begin
                p  = (c - 1) / 9;
                ph = (c - 1) % 9;
                exp_v[3] = 1'b1;
                exp_v[1] = (ph >= 2 && ph <= 4);
                exp_v[0] = (ph < 7) ? bits[p] : ~bits[p];
            end else if (c == 37) begin
                exp_v[2] = 1'b1;
            end
            n_checks++;
            if ({bus.BUSY, bus.DONE, bus.LAT_G, bus.LAT_D} !== exp_v)
                $display("FAIL ideal_wave c=%0d: got %b want %b (busy,done,g,d)",
                         c, {bus.BUSY, bus.DONE, bus.LAT_G, bus.LAT_D}, exp_v);
            else n_pass++;
            if (c == 37) begin
                n_checks++;
                if (bus.PASS !== 1'b1 || bus.ERR_CNT !== 8'd0)
                    $display("FAIL ideal_result: got pass=%b err=%0d want pass=1 err=0",
                             bus.PASS, bus.ERR_CNT);
                else n_pass++;
            end
            tick();
        end
        // Zero seed behaves like seed 1: first pattern bit is 1.
        start_run(8'h00, 8'd4);
        n_checks++;
        if (bus.LAT_D !== 1'b1) $display("FAIL zero_seed_bit: got %b want 1", bus.LAT_D);
        else n_pass++;
        begin
            int cyc;
            wait_done(100, cyc);
            n_checks++;
            if (cyc != 37) $display("FAIL zero_seed_len: got %0d want 37", cyc);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_stuck0();
        int cyc;
        mode = 2'd1;
        start_run(8'h01, 8'd4);
        wait_done(100, cyc);
        n_checks++;
        if (cyc != 37) $display("FAIL s0_len: got %0d want 37", cyc);
        else n_pass++;
        n_checks++;
        if (bus.ERR_CNT !== 8'd2) $display("FAIL s0_err: got %0d want 2", bus.ERR_CNT);
        else n_pass++;
        n_checks++;
        if (bus.FIRST_FAIL !== 8'd0) $display("FAIL s0_ff: got %0d want 0", bus.FIRST_FAIL);
        else n_pass++;
        n_checks++;
        if (bus.PASS !== 1'b0) $display("FAIL s0_pass: got %b want 0", bus.PASS);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.DONE !== 1'b0) $display("FAIL s0_done_pulse: got %b want 0", bus.DONE);
        else n_pass++;
    endtask

    task automatic test_stuck1();
        int cyc;
        mode = 2'd2;
        start_run(8'h01, 8'd4);
        wait_done(100, cyc);
        n_checks++;
        if (bus.ERR_CNT !== 8'd6) $display("FAIL s1_err: got %0d want 6", bus.ERR_CNT);
        else n_pass++;
        n_checks++;
        if (bus.FIRST_FAIL !== 8'd1) $display("FAIL s1_ff: got %0d want 1", bus.FIRST_FAIL);
        else n_pass++;
        tick();
    endtask

    task automatic test_transparent();
        int cyc;
        mode = 2'd3;
        start_run(8'h01, 8'd3);
        wait_done(100, cyc);
        n_checks++;
        if (cyc != 28) $display("FAIL tr_len: got %0d want 28", cyc);
        else n_pass++;
        n_checks++;
        if (bus.ERR_CNT !== 8'd3 || bus.FIRST_FAIL !== 8'd0)
            $display("FAIL tr_err: got err=%0d ff=%0d want err=3 ff=0", bus.ERR_CNT, bus.FIRST_FAIL);
        else n_pass++;
        tick();
    endtask

    task automatic test_empty();
        logic g_seen = 1'b0;
        mode = 2'd0;
        start_run(8'h5A, 8'd0);
        n_checks++;
        if ({bus.DONE, bus.PASS, bus.BUSY, bus.LAT_G} !== 4'b1100)
            $display("FAIL empty_done: got %b want 1100 (done,pass,busy,g)",
                     {bus.DONE, bus.PASS, bus.BUSY, bus.LAT_G});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.LAT_G === 1'b1 || bus.DONE === 1'b1) g_seen = 1'b1;
        end
        n_checks++;
        if (g_seen !== 1'b0 || bus.PASS !== 1'b1)
            $display("FAIL empty_after: got g_or_done=%b pass=%b want 0 and 1", g_seen, bus.PASS);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int  cyc;
        logic done_seen = 1'b0;
        mode = 2'd1;
        start_run(8'h01, 8'd4);
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (bus.LAT_G !== 1'b1 || bus.ERR_CNT !== 8'd2)
            $display("FAIL mid_pre: got g=%b err=%0d want g=1 err=2", bus.LAT_G, bus.ERR_CNT);
        else n_pass++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({bus.LAT_G, bus.BUSY, bus.DONE, bus.PASS} !== 4'b0000 || bus.ERR_CNT !== 8'd0)
            $display("FAIL mid_post: got g,busy,done,pass=%b err=%0d want 0000 err=0",
                     {bus.LAT_G, bus.BUSY, bus.DONE, bus.PASS}, bus.ERR_CNT);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.DONE === 1'b1) done_seen = 1'b1;
        end
        n_checks++;
        if (done_seen !== 1'b0) $display("FAIL mid_no_done: got %b want 0", done_seen);
        else n_pass++;
        mode = 2'd0;
        start_run(8'h01, 8'd4);
        wait_done(100, cyc);
        n_checks++;
        if (cyc != 37 || bus.PASS !== 1'b1)
            $display("FAIL mid_rerun: got cyc=%0d pass=%b want 37 and 1", cyc, bus.PASS);
        else n_pass++;
        tick();
    endtask

    // 255 patterns over a full LFSR period: 128 one-bits, 256 errors, saturated count.
    task automatic test_back_to_back();
        int cyc = 1;
        mode = 2'd1;
        start_run(8'h01, 8'd255);
        while (bus.DONE !== 1'b1 && cyc < 3000) begin
            if (cyc == 100 || cyc == 500) begin
                bus.SEED  = 8'h33;
                bus.NPAT  = 8'd2;
                bus.START = 1'b1;
            end
            tick();
            bus.START = 1'b0;
            cyc++;
        end
        n_checks++;
        if (cyc != 2296) $display("FAIL sat_len: got %0d want 2296", cyc);
        else n_pass++;
        n_checks++;
        if (bus.ERR_CNT !== 8'd255) $display("FAIL sat_err: got %0d want 255", bus.ERR_CNT);
        else n_pass++;
        n_checks++;
        if (bus.FIRST_FAIL !== 8'd0 || bus.PASS !== 1'b0)
            $display("FAIL sat_ff_pass: got ff=%0d pass=%b want 0 and 0", bus.FIRST_FAIL, bus.PASS);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck0();
        test_stuck1();
        test_transparent();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
